// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scancode decoder.
// Holds the state encoding, prefix bytes, tracked key codes and the held-flag mapping.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    localparam int PAUSE_TAIL_LEN = 7;

    localparam int HELD_SPACE = 0;
    localparam int HELD_UP    = 1;
    localparam int HELD_DOWN  = 2;
    localparam int HELD_ENTER = 3;

    // One-hot source bit for a tracked key; zero for anything untracked.
    function automatic logic [3:0] tracked_mask(input logic [7:0] code, input logic ext);
        logic [3:0] mask;
        mask = 4'b0000;
        if (!ext && code == KEY_SPACE) mask[HELD_SPACE] = 1'b1;
        if ( ext && code == KEY_UP)    mask[HELD_UP]    = 1'b1;
        if ( ext && code == KEY_DOWN)  mask[HELD_DOWN]  = 1'b1;
        if (!ext && code == KEY_ENTER) mask[HELD_ENTER] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/ps2_seq_timeout.sv
// Inter-byte timeout: loadable down-counter that expires after LIMIT idle cycles.
// A load in the expiry cycle takes priority, so a late byte still gets processed.
module ps2_seq_timeout #(
    parameter int LIMIT = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] START = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    assign o_expired = i_enable & ~i_load & (r_count == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= START;
        end else if (i_enable && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: turns the PS/2 byte stream into key events and
// maintains held flags for the game's jump/duck/start keys.
//
// state      | meaning
// IDLE       | waiting for the first byte of a sequence
// EXT        | E0 seen, next non-prefix byte is an extended make
// BRK        | F0 seen, next non-prefix byte is a break
// EXT_BRK    | E0 and F0 seen, next non-prefix byte is an extended break
// PAUSE      | E1 seen, swallowing the fixed-length pause tail
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 2500000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_received_data,
    input  logic       i_received_data_en,
    output logic [7:0] o_key_code,
    output logic       o_key_extended,
    output logic       o_key_released,
    output logic       o_key_event,
    output logic       o_jump_held,
    output logic       o_duck_held,
    output logic       o_start_held,
    output logic       o_seq_error
);
    ps2_state_t r_state;
    ps2_state_t w_next_state;
    logic [2:0] r_skip;
    logic [2:0] w_next_skip;

    logic       w_fire;
    logic [7:0] w_code;
    logic       w_ext;
    logic       w_rel;
    logic       w_expired;
    logic [3:0] w_mask;
    logic       w_repeat;
    logic       w_emit;

    logic [7:0] r_key_code;
    logic       r_key_extended;
    logic       r_key_released;
    logic       r_key_event;
    logic       r_seq_error;
    logic [3:0] r_held;

    ps2_seq_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (i_received_data_en),
        .i_enable (r_state != ST_IDLE),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_skip  <= w_next_skip;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_skip  = r_skip;
        w_fire       = 1'b0;
        w_code       = i_received_data;
        w_ext        = 1'b0;
        w_rel        = 1'b0;
        if (i_received_data_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_received_data == PFX_EXT) begin
                        w_next_state = ST_EXT;
                    end else if (i_received_data == PFX_BRK) begin
                        w_next_state = ST_BRK;
                    end else if (i_received_data == PFX_PAUSE) begin
                        w_next_state = ST_PAUSE;
                        w_next_skip  = 3'(PAUSE_TAIL_LEN);
                    end else begin
                        w_fire = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (i_received_data == PFX_BRK) begin
                        w_next_state = ST_EXT_BRK;
                    end else if (i_received_data != PFX_EXT) begin
                        w_fire       = 1'b1;
                        w_ext        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (i_received_data == PFX_EXT) begin
                        w_next_state = ST_EXT_BRK;
                    end else if (i_received_data != PFX_BRK) begin
                        w_fire       = 1'b1;
                        w_rel        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (i_received_data != PFX_EXT && i_received_data != PFX_BRK) begin
                        w_fire       = 1'b1;
                        w_ext        = 1'b1;
                        w_rel        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (r_skip <= 3'd1) begin
                        w_fire       = 1'b1;
                        w_code       = PFX_PAUSE;
                        w_next_skip  = 3'd0;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_skip = r_skip - 3'd1;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_skip  = 3'd0;
                end
            endcase
        end else if (w_expired) begin
            w_next_state = ST_IDLE;
            w_next_skip  = 3'd0;
        end
    end

    // A typematic make of a key already held is swallowed when suppression is on.
    assign w_mask   = tracked_mask(w_code, w_ext);
    assign w_repeat = SUPPRESS_REPEAT && !w_rel && ((w_mask & r_held) != 4'b0000);
    assign w_emit   = w_fire & ~w_repeat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_code     <= 8'h00;
            r_key_extended <= 1'b0;
            r_key_released <= 1'b0;
            r_key_event    <= 1'b0;
            r_seq_error    <= 1'b0;
            r_held         <= 4'b0000;
        end else begin
            r_key_event <= w_emit;
            r_seq_error <= w_expired;
            if (w_emit) begin
                r_key_code     <= w_code;
                r_key_extended <= w_ext;
                r_key_released <= w_rel;
            end
            if (w_fire) begin
                if (w_rel) begin
                    r_held <= r_held & ~w_mask;
                end else begin
                    r_held <= r_held | w_mask;
                end
            end
        end
    end

    assign o_key_code     = r_key_code;
    assign o_key_extended = r_key_extended;
    assign o_key_released = r_key_released;
    assign o_key_event    = r_key_event;
    assign o_seq_error    = r_seq_error;
    assign o_jump_held    = r_held[HELD_SPACE] | r_held[HELD_UP];
    assign o_duck_held    = r_held[HELD_DOWN];
    assign o_start_held   = r_held[HELD_ENTER];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed vector table, hand-written corner
// sequences and random byte streams checked against a sequence-level model.
module tb_ps2_scancode_decoder;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       en;

    logic [7:0] code_s, code_n;
    logic       ext_s, rel_s, ev_s, jump_s, duck_s, start_s, err_s;
    logic       ext_n, rel_n, ev_n, jump_n, duck_n, start_n, err_n;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_received_data(data), .i_received_data_en(en),
        .o_key_code(code_s), .o_key_extended(ext_s), .o_key_released(rel_s),
        .o_key_event(ev_s), .o_jump_held(jump_s), .o_duck_held(duck_s),
        .o_start_held(start_s), .o_seq_error(err_s)
    );

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b0)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_received_data(data), .i_received_data_en(en),
        .o_key_code(code_n), .o_key_extended(ext_n), .o_key_released(rel_n),
        .o_key_event(ev_n), .o_jump_held(jump_n), .o_duck_held(duck_n),
        .o_start_held(start_n), .o_seq_error(err_n)
    );

    logic [14:0] out_s, out_n;
    assign out_s = {ev_s, code_s, ext_s, rel_s, jump_s, duck_s, start_s, err_s};
    assign out_n = {ev_n, code_n, ext_n, rel_n, jump_n, duck_n, start_n, err_n};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the open sequence are queued; a sequence ends on
    // the first non-prefix byte, or after 8 bytes when it started with E1.
    logic [7:0] seq[$];
    int         idle_cnt;
    logic       m_held[4];
    logic       m_ev[2];
    logic [7:0] m_code[2];
    logic       m_ext[2];
    logic       m_rel[2];
    logic       m_err;

    function automatic int key_index(input logic [7:0] c, input logic x);
        if (!x && c == 8'h29) return 0;
        if ( x && c == 8'h75) return 1;
        if ( x && c == 8'h72) return 2;
        if (!x && c == 8'h5A) return 3;
        return -1;
    endfunction

    task automatic model_reset();
        seq.delete();
        idle_cnt = 0;
        m_err = 1'b0;
        for (int k = 0; k < 4; k++) m_held[k] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_ev[k] = 1'b0; m_code[k] = 8'h00; m_ext[k] = 1'b0; m_rel[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic e, input logic [7:0] d);
        logic done, x, r;
        logic [7:0] c;
        int idx;
        done = 1'b0; x = 1'b0; r = 1'b0; c = d;
        m_err = 1'b0;
        m_ev[0] = 1'b0;
        m_ev[1] = 1'b0;
        if (e) begin
            idle_cnt = 0;
            seq.push_back(d);
            if (seq[0] == 8'hE1) begin
                if (seq.size() == 8) begin
                    done = 1'b1; c = 8'hE1;
                end
            end else if (d != 8'hE0 && d != 8'hF0) begin
                done = 1'b1;
                foreach (seq[i]) begin
                    if (seq[i] == 8'hE0) x = 1'b1;
                    if (seq[i] == 8'hF0) r = 1'b1;
                end
            end
            if (done) begin
                seq.delete();
                idx = key_index(c, x);
                for (int k = 0; k < 2; k++) begin
                    if (!(k == 0 && !r && idx >= 0 && m_held[idx])) begin
                        m_ev[k] = 1'b1; m_code[k] = c; m_ext[k] = x; m_rel[k] = r;
                    end
                end
                if (idx >= 0) m_held[idx] = !r;
            end
        end else if (seq.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                m_err = 1'b1;
                seq.delete();
                idle_cnt = 0;
            end
        end
    endtask

    function automatic logic [14:0] model_out(input int k);
        return {m_ev[k], m_code[k], m_ext[k], m_rel[k],
                m_held[0] | m_held[1], m_held[2], m_held[3], m_err};
    endfunction

    task automatic step(input logic e, input logic [7:0] d);
        en = e;
        data = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        model_step(e, d);
        check("model_sup", out_s, model_out(0));
        check("model_rep", out_n, model_out(1));
    endtask

    task automatic pulse_reset();
        en = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("reset_sup", out_s, 15'd0);
        check("reset_rep", out_n, 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       j;
        logic       dk;
        logic       s;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(input logic [7:0] d, input logic ev, input logic [7:0] code,
                                input logic ext, input logic rel, input logic j,
                                input logic dk, input logic s);
        vec_t v;
        v.d = d; v.ev = ev; v.code = code; v.ext = ext; v.rel = rel;
        v.j = j; v.dk = dk; v.s = s;
        return v;
    endfunction

    logic [7:0] pick;
    int         r;

    initial begin
        //              byte   ev  code   x  r  j  d  s
        vecs[0]  = mk(8'h29, 1, 8'h29, 0, 0, 1, 0, 0);
        vecs[1]  = mk(8'hF0, 0, 8'h29, 0, 0, 1, 0, 0);
        vecs[2]  = mk(8'h29, 1, 8'h29, 0, 1, 0, 0, 0);
        vecs[3]  = mk(8'hE0, 0, 8'h29, 0, 1, 0, 0, 0);
        vecs[4]  = mk(8'h72, 1, 8'h72, 1, 0, 0, 1, 0);
        vecs[5]  = mk(8'hE0, 0, 8'h72, 1, 0, 0, 1, 0);
        vecs[6]  = mk(8'hF0, 0, 8'h72, 1, 0, 0, 1, 0);
        vecs[7]  = mk(8'h72, 1, 8'h72, 1, 1, 0, 0, 0);
        vecs[8]  = mk(8'h29, 1, 8'h29, 0, 0, 1, 0, 0);
        vecs[9]  = mk(8'h29, 0, 8'h29, 0, 0, 1, 0, 0);
        vecs[10] = mk(8'h29, 0, 8'h29, 0, 0, 1, 0, 0);
        vecs[11] = mk(8'hE0, 0, 8'h29, 0, 0, 1, 0, 0);
        vecs[12] = mk(8'h75, 1, 8'h75, 1, 0, 1, 0, 0);
        vecs[13] = mk(8'hF0, 0, 8'h75, 1, 0, 1, 0, 0);
        vecs[14] = mk(8'h29, 1, 8'h29, 0, 1, 1, 0, 0);
        vecs[15] = mk(8'hE0, 0, 8'h29, 0, 1, 1, 0, 0);
        vecs[16] = mk(8'hF0, 0, 8'h29, 0, 1, 1, 0, 0);
        vecs[17] = mk(8'h75, 1, 8'h75, 1, 1, 0, 0, 0);
        vecs[18] = mk(8'hE1, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[19] = mk(8'h14, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[20] = mk(8'h77, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[21] = mk(8'hE1, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[22] = mk(8'hF0, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[23] = mk(8'h14, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[24] = mk(8'hF0, 0, 8'h75, 1, 1, 0, 0, 0);
        vecs[25] = mk(8'h77, 1, 8'hE1, 0, 0, 0, 0, 0);
        vecs[26] = mk(8'h5A, 1, 8'h5A, 0, 0, 0, 0, 1);
        vecs[27] = mk(8'hF0, 0, 8'h5A, 0, 0, 0, 0, 1);
        vecs[28] = mk(8'h5A, 1, 8'h5A, 0, 1, 0, 0, 0);

        rst_n = 1'b0;
        en = 1'b0;
        data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // Directed vectors, strobed on consecutive cycles.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].d);
            check($sformatf("vec%0d", i), out_s,
                  {vecs[i].ev, vecs[i].code, vecs[i].ext, vecs[i].rel,
                   vecs[i].j, vecs[i].dk, vecs[i].s, 1'b0});
        end

        // Timeout after E0: error exactly TMO cycles after the strobe, no event.
        step(1'b1, 8'hE0);
        for (int i = 1; i < TMO; i++) step(1'b0, 8'h00);
        check("tmo_early", {13'd0, ev_s, err_s}, 15'd0);
        step(1'b0, 8'h00);
        check("tmo_err", {13'd0, ev_s, err_s}, 15'd1);
        step(1'b0, 8'h00);
        check("tmo_pulse", {13'd0, ev_s, err_s}, 15'd0);
        step(1'b1, 8'h5A);
        check("tmo_recover", {6'd0, ev_s, code_s, start_s}, {6'd0, 1'b1, 8'h5A, 1'b1});

        // Strobe landing on the expiry cycle wins over the timeout.
        step(1'b1, 8'hE0);
        for (int i = 1; i < TMO; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h5A);
        check("tmo_race", {4'd0, ev_s, code_s, ext_s, rel_s, err_s},
              {4'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0});
        step(1'b1, 8'hF0);
        step(1'b1, 8'h5A);

        // Reset between F0 and the key byte.
        step(1'b1, 8'h5A);
        check("rst_pre", {14'd0, start_s}, 15'd1);
        step(1'b1, 8'hF0);
        @(negedge clk);
        pulse_reset();
        step(1'b1, 8'h29);
        check("rst_make", {4'd0, ev_s, code_s, rel_s, jump_s, start_s},
              {4'd0, 1'b1, 8'h29, 1'b0, 1'b1, 1'b0});
        step(1'b1, 8'hF0);
        step(1'b1, 8'h29);

        // Random byte stream with occasional gaps long enough to time out.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                repeat ($urandom_range(90, 120)) step(1'b0, 8'h00);
            end else if (r < 50) begin
                step(1'b0, 8'h00);
            end else begin
                case ($urandom_range(0, 9))
                    0: pick = 8'hE0;
                    1: pick = 8'hF0;
                    2: pick = 8'hE1;
                    3: pick = 8'h29;
                    4: pick = 8'h75;
                    5: pick = 8'h72;
                    6: pick = 8'h5A;
                    default: pick = 8'($urandom());
                endcase
                step(1'b1, pick);
            end
            if (i == 2000) begin
                @(negedge clk);
                pulse_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver. Consumes its received_data / received_data_en byte stream.
- Decodes Set-2 scancode sequences (plain, E0-extended, F0 break, E1 pause) into single-cycle key events.
- Maintains held-state flags for the game's control keys (jump, duck, start), which the game FSM reads directly.

Parameters:
- TIMEOUT_CYCLES, 2500000, max clk cycles allowed between bytes of one sequence (50 ms @ 50 MHz); counter width = $clog2(TIMEOUT_CYCLES+1).
- SUPPRESS_REPEAT, 1, when 1 typematic repeat makes of an already-held tracked key produce no key_event.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- received_data  in  8  byte from PS/2 receiver, valid only when received_data_en=1
- received_data_en  in  1  one-cycle strobe, new byte
- key_code  out  8  final scancode of last decoded event
- key_extended  out  1  last event was E0-prefixed
- key_released  out  1  last event was a break (F0)
- key_event  out  1  one-cycle pulse; key_code/key_extended/key_released valid the same cycle and held afterwards
- jump_held  out  1  space (29) or up (E0 75) currently held
- duck_held  out  1  down (E0 72) currently held
- start_held  out  1  enter (5A) currently held
- seq_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; timeout counter 0; E1 skip counter 0.
- State machine, advances only on received_data_en=1 except timeout:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE (skip=7); any other byte->emit make (ext=0), stay IDLE.
  - EXT: F0->EXT_BRK; E0->stay EXT (duplicate prefix tolerated); other->emit make (ext=1), ->IDLE.
  - BRK: other->emit break (ext=0), ->IDLE; E0/F0 while in BRK->treat as new prefix (E0->EXT_BRK, F0 stay).
  - EXT_BRK: other->emit break (ext=1), ->IDLE.
  - PAUSE: decrement skip per byte; at skip 1->0 emit key_code=E1, ext=0, released=0, ->IDLE. No break event for pause.
- Emit means, registered, one cycle after the final byte's strobe:
  - key_event=1; key_code/key_extended/key_released updated.
  - Held flags are updated in the same cycle.
- Held flags:
  - Make of a tracked key sets its source bit.
  - Break clears it.
  - jump_held = space_bit OR up_bit.
  - Untracked keys do not affect the flags.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - A make of a tracked key whose source bit is already 1 produces no key_event; outputs are unchanged.
  - Untracked keys always emit.
- Timeout:
  - Counter clears on every strobe; counts while state != IDLE.
  - When it reaches TIMEOUT_CYCLES: state->IDLE, seq_error pulses, no key_event.
  - A strobe in the same cycle as timeout wins: the byte is processed and no error is raised.
- Latency: key_event exactly 1 clk after the strobe of the terminating byte.
- Back-to-back strobes on consecutive cycles must be handled (the receiver cannot produce them, but the bench drives them).
- Reset asserted mid-sequence: immediate return to IDLE; held flags cleared.

Decomposition:
- Shared package ps2_pkg: state encoding localparams, prefix constants (8'hE0, 8'hF0, 8'hE1), tracked key codes (8'h29, 8'h75, 8'h72, 8'h5A), PAUSE_TAIL_LEN=7.
- One sub-module: ps2_seq_timeout, a loadable down/up counter with clear and expiry pulse, instantiated once.
- FSM, emit register and held flags stay in the top module.

Test Plan:
- Bytes 29, then F0 29 -> event code=29 ext=0 rel=0, jump_held=1; then event code=29 rel=1, jump_held=0.
- Bytes E0 72, E0 F0 72 -> event code=72 ext=1 rel=0, duck_held=1; then ext=1 rel=1, duck_held=0.
- Bytes 29 29 29 (repeat) with SUPPRESS_REPEAT=1 -> exactly one key_event; with SUPPRESS_REPEAT=0 -> three events.
- Space held plus up make, then space break -> jump_held stays 1 until the up break E0 F0 75 arrives.
- E1 14 77 E1 F0 14 F0 77 -> a single event code=E1 after the 8th byte; no held flag changes.
- E0, then no byte for TIMEOUT_CYCLES (set to 100 in bench) -> seq_error pulse at cycle 100, no event; then 5A -> start_held=1.
- Reset pulse between F0 and 29 -> flags 0; the following 29 is decoded as a make.
